// File: rtl/wash_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : wash_seq_if
// Description : Control, duration, sensor and actuator bundle for wash_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface wash_seq_if #(
    parameter int TW = 8
);
    logic          tick;
    logic          start;
    logic          abort;
    logic          pause;
    logic [TW-1:0] wash_time;
    logic [TW-1:0] rinse_time;
    logic [TW-1:0] spin_time;
    logic          level_full;
    logic          level_empty;
    logic          valve_in;
    logic          valve_out;
    logic          motor_on;
    logic          motor_fast;
    logic [2:0]    state;
    logic [TW-1:0] remaining;
    logic          busy;
    logic          done;

    modport master (
        output tick, start, abort, pause, wash_time, rinse_time, spin_time,
               level_full, level_empty,
        input  valve_in, valve_out, motor_on, motor_fast, state, remaining,
               busy, done
    );

    modport slave (
        input  tick, start, abort, pause, wash_time, rinse_time, spin_time,
               level_full, level_empty,
        output valve_in, valve_out, motor_on, motor_fast, state, remaining,
               busy, done
    );
endinterface
`default_nettype wire

// File: rtl/wash_seq.sv
`default_nettype none
// ============================================================================
// Module      : wash_seq
// Description : Washing-machine sequencer: fill, wash, drain, rinse, spin.
// Revision    : 1.0 - initial release
// ============================================================================
module wash_seq #(
    parameter int TW      = 8,
    parameter int FILL_TO = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    wash_seq_if.slave  bus
);
    localparam logic [2:0]    c_ST_IDLE  = 3'd0;
    localparam logic [2:0]    c_ST_FILL  = 3'd1;
    localparam logic [2:0]    c_ST_WASH  = 3'd2;
    localparam logic [2:0]    c_ST_DRAIN = 3'd3;
    localparam logic [2:0]    c_ST_RINSE = 3'd4;
    localparam logic [2:0]    c_ST_SPIN  = 3'd5;
    localparam logic [2:0]    c_ST_ERR   = 3'd7;
    localparam logic [TW-1:0] c_ONE      = TW'(1);
    localparam logic [TW-1:0] c_TMO_LAST = TW'(FILL_TO - 1);

    logic [2:0]    r_state, w_state_d;
    logic [TW-1:0] r_timer, w_timer_d;
    logic [TW-1:0] r_tmo, w_tmo_d;
    logic [TW-1:0] r_wash, r_rinse, r_spin;
    logic          r_rinse_pass, w_rp_d;
    logic          r_aborting, w_ab_d;
    logic          r_done, w_done_d;
    logic          w_state_en, w_timer_en, w_tmo_en, w_dur_en, w_rp_en, w_ab_en;
    logic          w_timed;
    logic          w_act;

    always_comb begin
        w_state_en = 1'b0;  w_state_d = r_state;
        w_timer_en = 1'b0;  w_timer_d = r_timer;
        w_tmo_en   = 1'b0;  w_tmo_d   = r_tmo;
        w_rp_en    = 1'b0;  w_rp_d    = r_rinse_pass;
        w_ab_en    = 1'b0;  w_ab_d    = r_aborting;
        w_dur_en   = 1'b0;
        w_done_d   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_state_en = 1'b1;  w_state_d = c_ST_FILL;
                    w_dur_en   = 1'b1;
                    w_rp_en    = 1'b1;  w_rp_d    = 1'b0;
                    w_ab_en    = 1'b1;  w_ab_d    = 1'b0;
                    w_tmo_en   = 1'b1;  w_tmo_d   = '0;
                end
            end
            c_ST_ERR: begin
                if (bus.abort) begin
                    w_state_en = 1'b1;  w_state_d = c_ST_IDLE;
                end
            end
            default: begin
                if (bus.abort) begin
                    w_ab_en = 1'b1;  w_ab_d = 1'b1;
                    if (r_state != c_ST_DRAIN) begin
                        w_state_en = 1'b1;  w_state_d = c_ST_DRAIN;
                        w_tmo_en   = 1'b1;  w_tmo_d   = '0;
                    end else if (bus.tick && !bus.pause && r_tmo < c_TMO_LAST) begin
                        // Keep timing the drain, but saturate so a held abort cannot wrap it
                        w_tmo_en = 1'b1;  w_tmo_d = r_tmo + c_ONE;
                    end
                end else if (!bus.pause) begin
                    case (r_state)
                        c_ST_FILL: begin
                            if (bus.level_full) begin
                                w_state_en = 1'b1;
                                w_timer_en = 1'b1;
                                w_state_d  = r_rinse_pass ? c_ST_RINSE : c_ST_WASH;
                                w_timer_d  = r_rinse_pass ? r_rinse : r_wash;
                            end else if (bus.tick) begin
                                if (r_tmo >= c_TMO_LAST) begin
                                    w_state_en = 1'b1;  w_state_d = c_ST_ERR;
                                end else begin
                                    w_tmo_en = 1'b1;  w_tmo_d = r_tmo + c_ONE;
                                end
                            end
                        end
                        c_ST_DRAIN: begin
                            if (bus.level_empty) begin
                                w_state_en = 1'b1;
                                if (r_aborting) begin
                                    w_state_d = c_ST_IDLE;
                                end else if (!r_rinse_pass) begin
                                    w_state_d = c_ST_FILL;
                                    w_rp_en   = 1'b1;  w_rp_d  = 1'b1;
                                    w_tmo_en  = 1'b1;  w_tmo_d = '0;
                                end else begin
                                    w_state_d  = c_ST_SPIN;
                                    w_timer_en = 1'b1;  w_timer_d = r_spin;
                                end
                            end else if (bus.tick) begin
                                if (r_tmo >= c_TMO_LAST) begin
                                    w_state_en = 1'b1;  w_state_d = c_ST_ERR;
                                end else begin
                                    w_tmo_en = 1'b1;  w_tmo_d = r_tmo + c_ONE;
                                end
                            end
                        end
                        c_ST_WASH, c_ST_RINSE, c_ST_SPIN: begin
                            if (bus.tick) begin
                                // A timer of 0 or 1 both expire on this tick, so T=0 acts as T=1
                                if (r_timer <= c_ONE) begin
                                    w_state_en = 1'b1;
                                    if (r_state == c_ST_SPIN) begin
                                        w_state_d = c_ST_IDLE;
                                        w_done_d  = 1'b1;
                                    end else begin
                                        w_state_d = c_ST_DRAIN;
                                        w_tmo_en  = 1'b1;  w_tmo_d = '0;
                                    end
                                end else begin
                                    w_timer_en = 1'b1;  w_timer_d = r_timer - c_ONE;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_state <= c_ST_IDLE;
        else if (w_state_en) r_state <= w_state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_timer <= '0;
        else if (w_timer_en) r_timer <= w_timer_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_tmo <= '0;
        else if (w_tmo_en) r_tmo <= w_tmo_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wash  <= '0;
            r_rinse <= '0;
            r_spin  <= '0;
        end else if (w_dur_en) begin
            r_wash  <= bus.wash_time;
            r_rinse <= bus.rinse_time;
            r_spin  <= bus.spin_time;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_rinse_pass <= 1'b0;
        else if (w_rp_en) r_rinse_pass <= w_rp_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_aborting <= 1'b0;
        else if (w_ab_en) r_aborting <= w_ab_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_done <= 1'b0;
        else        r_done <= w_done_d;
    end

    assign w_timed = (r_state == c_ST_WASH) || (r_state == c_ST_RINSE) || (r_state == c_ST_SPIN);
    assign w_act   = ~bus.pause;

    assign bus.valve_in   = w_act && (r_state == c_ST_FILL);
    assign bus.valve_out  = w_act && ((r_state == c_ST_DRAIN) || (r_state == c_ST_SPIN));
    assign bus.motor_on   = w_act && w_timed;
    assign bus.motor_fast = w_act && (r_state == c_ST_SPIN);
    assign bus.state      = r_state;
    assign bus.remaining  = w_timed ? r_timer : '0;
    assign bus.busy       = (r_state != c_ST_IDLE);
    assign bus.done       = r_done;
endmodule
`default_nettype wire

// File: tb/tb_wash_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_wash_seq
// Description : Self-checking bench for wash_seq with a state/done event scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wash_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] exp_q[$];
    logic [2:0] prev_state = 3'd0;
    logic [3:0] act;

    wash_seq_if #(.TW(8)) bus ();

    wash_seq #(.TW(8), .FILL_TO(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign act = {bus.valve_in, bus.valve_out, bus.motor_on, bus.motor_fast};

    // Each state change (or done pulse) is one event {done, state}
    always @(negedge clk) begin : mon
        logic [3:0] ev;
        logic [3:0] want;
        if (bus.state !== prev_state || bus.done === 1'b1) begin
            ev = {bus.done, bus.state};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_event: got %h, nothing expected", ev);
            end else begin
                want = exp_q.pop_front();
                if (ev !== want) $display("FAIL sb_event: got %h expected %h", ev, want);
                else n_pass++;
            end
        end
        prev_state = bus.state;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic t);
        bus.tick = t;
        @(posedge clk); #1;
        bus.tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.tick = 0; bus.start = 0; bus.abort = 0; bus.pause = 0;
        bus.wash_time = 0; bus.rinse_time = 0; bus.spin_time = 0;
        bus.level_full = 0; bus.level_empty = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.state, act, bus.busy, bus.done, bus.remaining} !== 17'd0)
            $display("FAIL reset_outputs: got st=%0d act=%b busy=%b done=%b rem=%0d, want all 0",
                     bus.state, act, bus.busy, bus.done, bus.remaining);
        else n_pass++;
        rst_n = 1'b1;
        step(1'b1);
        @(negedge clk);
        n_checks++;
        if (bus.state !== 3'd0) $display("FAIL reset_idle_tick: got %0d want 0", bus.state);
        else n_pass++;
    endtask

    task automatic test_full_program;
        bus.wash_time = 8'd3; bus.rinse_time = 8'd2; bus.spin_time = 8'd4;
        bus.start = 1; exp_q.push_back(4'h1); step(0); bus.start = 0;
        bus.wash_time = 8'd9; bus.rinse_time = 8'd9; bus.spin_time = 8'd9;
        @(negedge clk);
        n_checks++;
        if ({act, bus.busy} !== 5'b10001) $display("FAIL full_fill_out: got act=%b busy=%b want 1000/1", act, bus.busy);
        else n_pass++;
        ticks(2);
        bus.level_full = 1; exp_q.push_back(4'h2); step(0); bus.level_full = 0;
        @(negedge clk);
        n_checks++;
        if ({act, bus.remaining} !== {4'b0010, 8'd3}) $display("FAIL full_wash_entry: got act=%b rem=%0d want 0010/3", act, bus.remaining);
        else n_pass++;
        ticks(2);
        @(negedge clk);
        n_checks++;
        if ({bus.state, bus.remaining} !== {3'd2, 8'd1}) $display("FAIL full_wash_len: got st=%0d rem=%0d want 2/1", bus.state, bus.remaining);
        else n_pass++;
        exp_q.push_back(4'h3); step(1);
        @(negedge clk);
        n_checks++;
        if ({act, bus.remaining} !== {4'b0100, 8'd0}) $display("FAIL full_drain_out: got act=%b rem=%0d want 0100/0", act, bus.remaining);
        else n_pass++;
        ticks(2);
        bus.level_empty = 1; exp_q.push_back(4'h1); step(0); bus.level_empty = 0;
        ticks(2);
        bus.level_full = 1; exp_q.push_back(4'h4); step(0); bus.level_full = 0;
        @(negedge clk);
        n_checks++;
        if ({act, bus.remaining} !== {4'b0010, 8'd2}) $display("FAIL full_rinse_entry: got act=%b rem=%0d want 0010/2", act, bus.remaining);
        else n_pass++;
        step(1);
        exp_q.push_back(4'h3); step(1);
        ticks(2);
        bus.level_empty = 1; exp_q.push_back(4'h5); step(0); bus.level_empty = 0;
        @(negedge clk);
        n_checks++;
        if ({act, bus.remaining} !== {4'b0111, 8'd4}) $display("FAIL full_spin_entry: got act=%b rem=%0d want 0111/4", act, bus.remaining);
        else n_pass++;
        ticks(3);
        @(negedge clk);
        n_checks++;
        if ({bus.state, bus.remaining} !== {3'd5, 8'd1}) $display("FAIL full_spin_len: got st=%0d rem=%0d want 5/1", bus.state, bus.remaining);
        else n_pass++;
        exp_q.push_back(4'h8); step(1);
        @(negedge clk);
        n_checks++;
        if ({bus.done, bus.busy, act} !== 6'b100000) $display("FAIL full_done: got done=%b busy=%b act=%b want 1/0/0000", bus.done, bus.busy, act);
        else n_pass++;
        step(0);
        @(negedge clk); #1;
        n_checks++;
        if (bus.done !== 1'b0) $display("FAIL full_done_width: got %b want 0", bus.done);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL full_events_left: got %0d want 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_pause;
        bus.wash_time = 8'd4;
        bus.start = 1; exp_q.push_back(4'h1); step(0); bus.start = 0;
        bus.pause = 1; bus.level_full = 1;
        ticks(2);
        @(negedge clk);
        n_checks++;
        if ({bus.state, act} !== {3'd1, 4'b0000}) $display("FAIL pause_fill: got st=%0d act=%b want 1/0000", bus.state, act);
        else n_pass++;
        bus.pause = 0; exp_q.push_back(4'h2); step(0); bus.level_full = 0;
        ticks(2);
        bus.pause = 1;
        ticks(5);
        @(negedge clk);
        n_checks++;
        if ({bus.state, act, bus.remaining} !== {3'd2, 4'b0000, 8'd2}) $display("FAIL pause_wash_hold: got st=%0d act=%b rem=%0d want 2/0000/2", bus.state, act, bus.remaining);
        else n_pass++;
        bus.pause = 0;
        step(1);
        @(negedge clk);
        n_checks++;
        if ({bus.state, act, bus.remaining} !== {3'd2, 4'b0010, 8'd1}) $display("FAIL pause_resume: got st=%0d act=%b rem=%0d want 2/0010/1", bus.state, act, bus.remaining);
        else n_pass++;
        exp_q.push_back(4'h3); step(1);
        bus.abort = 1; step(0); bus.abort = 0;
        @(negedge clk);
        n_checks++;
        if (bus.state !== 3'd3) $display("FAIL pause_abort_drain: got %0d want 3", bus.state);
        else n_pass++;
        bus.level_empty = 1; exp_q.push_back(4'h0); step(0); bus.level_empty = 0;
        @(negedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL pause_events_left: got %0d want 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_timeout;
        bus.start = 1; exp_q.push_back(4'h1); step(0); bus.start = 0;
        ticks(19);
        @(negedge clk);
        n_checks++;
        if (bus.state !== 3'd1) $display("FAIL tmo_19: got %0d want 1", bus.state);
        else n_pass++;
        exp_q.push_back(4'h7); step(1);
        ticks(3);
        @(negedge clk);
        n_checks++;
        if ({bus.state, act, bus.busy} !== {3'd7, 4'b0000, 1'b1}) $display("FAIL tmo_err: got st=%0d act=%b busy=%b want 7/0000/1", bus.state, act, bus.busy);
        else n_pass++;
        bus.abort = 1; exp_q.push_back(4'h0); step(0); bus.abort = 0;
        @(negedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL tmo_events_left: got %0d want 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_timeout_race;
        bus.wash_time = 8'd5;
        bus.start = 1; exp_q.push_back(4'h1); step(0); bus.start = 0;
        ticks(19);
        bus.level_full = 1; exp_q.push_back(4'h2); step(1); bus.level_full = 0;
        @(negedge clk);
        n_checks++;
        if ({bus.state, bus.remaining} !== {3'd2, 8'd5}) $display("FAIL race_wash: got st=%0d rem=%0d want 2/5", bus.state, bus.remaining);
        else n_pass++;
        bus.abort = 1; exp_q.push_back(4'h3); step(1); bus.abort = 0;
        bus.level_empty = 1; exp_q.push_back(4'h0); step(0); bus.level_empty = 0;
        @(negedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL race_events_left: got %0d want 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_zero_wash;
        bus.wash_time = 8'd0;
        bus.start = 1; exp_q.push_back(4'h1); step(0); bus.start = 0;
        bus.level_full = 1; exp_q.push_back(4'h2); step(0); bus.level_full = 0;
        step(0);
        @(negedge clk);
        n_checks++;
        if ({bus.state, bus.remaining} !== {3'd2, 8'd0}) $display("FAIL zero_wash_hold: got st=%0d rem=%0d want 2/0", bus.state, bus.remaining);
        else n_pass++;
        exp_q.push_back(4'h3); step(1);
        @(negedge clk);
        n_checks++;
        if (bus.state !== 3'd3) $display("FAIL zero_wash_len: got %0d want 3", bus.state);
        else n_pass++;
        bus.abort = 1; step(0); bus.abort = 0;
        bus.level_empty = 1; exp_q.push_back(4'h0); step(0); bus.level_empty = 0;
        @(negedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL zero_events_left: got %0d want 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    // Short program up to RINSE with one-tick wash and rinse=5
    task automatic run_to_rinse;
        bus.wash_time = 8'd1; bus.rinse_time = 8'd5; bus.spin_time = 8'd5;
        bus.start = 1; exp_q.push_back(4'h1); step(0); bus.start = 0;
        bus.level_full = 1; exp_q.push_back(4'h2); step(0); bus.level_full = 0;
        exp_q.push_back(4'h3); step(1);
        bus.level_empty = 1; exp_q.push_back(4'h1); step(0); bus.level_empty = 0;
        bus.level_full = 1; exp_q.push_back(4'h4); step(0); bus.level_full = 0;
    endtask

    task automatic test_abort_spin;
        run_to_rinse();
        ticks(4);
        exp_q.push_back(4'h3); step(1);
        bus.level_empty = 1; exp_q.push_back(4'h5); step(0); bus.level_empty = 0;
        step(1);
        bus.abort = 1; bus.pause = 1; exp_q.push_back(4'h3); step(1); bus.abort = 0;
        @(negedge clk);
        n_checks++;
        if ({bus.state, act} !== {3'd3, 4'b0000}) $display("FAIL abort_spin_paused: got st=%0d act=%b want 3/0000", bus.state, act);
        else n_pass++;
        bus.pause = 0;
        #1;
        n_checks++;
        if (act !== 4'b0100) $display("FAIL abort_spin_drain: got act=%b want 0100", act);
        else n_pass++;
        bus.level_empty = 1; exp_q.push_back(4'h0); step(0); bus.level_empty = 0;
        @(negedge clk);
        n_checks++;
        if ({bus.state, bus.done} !== 4'd0) $display("FAIL abort_spin_nodone: got st=%0d done=%b want 0/0", bus.state, bus.done);
        else n_pass++;
        #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL abort_events_left: got %0d want 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_start_abort;
        bus.start = 1; bus.abort = 1; step(0); step(1); bus.start = 0; bus.abort = 0;
        @(negedge clk);
        n_checks++;
        if ({bus.state, bus.busy} !== 4'd0) $display("FAIL start_abort: got st=%0d busy=%b want 0/0", bus.state, bus.busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        run_to_rinse();
        step(1);
        exp_q.push_back(4'h0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.state, act, bus.busy, bus.done, bus.remaining} !== 17'd0)
            $display("FAIL reset_mid: got st=%0d act=%b busy=%b done=%b rem=%0d want all 0",
                     bus.state, act, bus.busy, bus.done, bus.remaining);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ticks(3);
        @(negedge clk); #1;
        n_checks++;
        if ({bus.state, bus.done} !== 4'd0) $display("FAIL reset_mid_wait: got st=%0d done=%b want 0/0", bus.state, bus.done);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL reset_events_left: got %0d want 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_full_program();
        test_pause();
        test_timeout();
        test_timeout_race();
        test_zero_wash();
        test_abort_spin();
        test_start_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
